bcd_updown_counter: RTL and testbench

- Parametrised multi-digit BCD counter; successor to the single-digit 0~9 counter.
- Counts up or down over 0..TOP with synchronous parallel load and enable.
- Provides look-ahead carry/borrow outputs so instances cascade, e.g. seconds/minutes/hours chains in the digital clock and timer designs.
- One clock, synchronous active-high clear.

---
 rtl/bcd_updown_counter.sv | 87 ++++++++
 tb/tb_bcd_updown_counter.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter over 0..TOP with synchronous clear,
// parallel load (sanitised) and look-ahead carry/borrow for cascading.
module bcd_updown_counter #(
    parameter int DIGITS = 4,
    parameter int TOP    = 9999
) (
    input  logic                  CP,
    input  logic                  CR,
    input  logic                  EN,
    input  logic                  UP,
    input  logic                  LD,
    input  logic [4*DIGITS-1:0]   D,
    output logic [4*DIGITS-1:0]   Q,
    output logic                  CO,
    output logic                  BO
);
    localparam int W = 4 * DIGITS;

    // Decimal integer to packed BCD, evaluated at elaboration
    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r;
        int           t;
        r = '0;
        t = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    localparam logic [W-1:0] TOP_BCD = to_bcd(TOP);

    logic [W-1:0]      inc_val;
    logic [W-1:0]      dec_val;
    logic [W-1:0]      ld_clamp;
    logic [W-1:0]      ld_val;
    logic [DIGITS-1:0] cy;      // digit g takes an increment
    logic [DIGITS-1:0] bw;      // digit g takes a decrement
    logic              at_top;
    logic              at_zero;

    // Per-digit ripple: a digit moves only if every lower digit rolls over
    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
        logic [3:0] dq;
        logic [3:0] dd;
        assign dq = Q[4*g +: 4];
        assign dd = D[4*g +: 4];

        if (g == 0) begin : g_lsd
            assign cy[g] = 1'b1;
            assign bw[g] = 1'b1;
        end else begin : g_hsd
            assign cy[g] = cy[g-1] & (Q[4*(g-1) +: 4] == 4'd9);
            assign bw[g] = bw[g-1] & (Q[4*(g-1) +: 4] == 4'd0);
        end

        assign inc_val[4*g +: 4]  = !cy[g] ? dq : ((dq >= 4'd9) ? 4'd0 : dq + 4'd1);
        assign dec_val[4*g +: 4]  = !bw[g] ? dq : ((dq == 4'd0) ? 4'd9 : dq - 4'd1);
        // Non-BCD load digits saturate at 9
        assign ld_clamp[4*g +: 4] = (dd > 4'd9) ? 4'd9 : dd;
    end

    // With all digits valid BCD, binary compare equals decimal compare
    assign ld_val  = (ld_clamp > TOP_BCD) ? TOP_BCD : ld_clamp;
    assign at_top  = (Q == TOP_BCD);
    assign at_zero = (Q == '0);

    // Look-ahead terminal flags; drive the next stage's EN directly
    assign CO = EN &  UP & at_top;
    assign BO = EN & ~UP & at_zero;

    // Count register: clear > load > count > hold; wrap uses the full TOP
    always_ff @(posedge CP) begin
        if (CR) begin
            Q <= '0;
        end else if (LD) begin
            Q <= ld_val;
        end else if (EN) begin
            if (UP) begin
                Q <= at_top ? '0 : inc_val;
            end else begin
                Q <= at_zero ? TOP_BCD : dec_val;
            end
        end
    end
endmodule

// File: tb/tb_bcd_updown_counter.sv
// Directed bench: 2-digit mod-60 counter, a cascaded minutes stage and a
// 4-digit 0..9999 instance.
module tb_bcd_updown_counter;
    logic        clk;
    logic        cr;
    logic        en, up, ld;
    logic [7:0]  d;
    logic [7:0]  q_s, q_m;
    logic        co_s, bo_s, co_m, bo_m;
    logic        w_en, w_up, w_ld;
    logic [15:0] w_d, w_q;
    logic        w_co, w_bo;

    int errors = 0;
    int checks = 0;
    int sec_m, min_m;

    bcd_updown_counter #(.DIGITS(2), .TOP(59)) u_sec (
        .CP(clk), .CR(cr), .EN(en), .UP(up), .LD(ld), .D(d),
        .Q(q_s), .CO(co_s), .BO(bo_s)
    );

    bcd_updown_counter #(.DIGITS(2), .TOP(59)) u_min (
        .CP(clk), .CR(cr), .EN(co_s), .UP(1'b1), .LD(1'b0), .D(8'h00),
        .Q(q_m), .CO(co_m), .BO(bo_m)
    );

    bcd_updown_counter #(.DIGITS(4), .TOP(9999)) u_wide (
        .CP(clk), .CR(cr), .EN(w_en), .UP(w_up), .LD(w_ld), .D(w_d),
        .Q(w_q), .CO(w_co), .BO(w_bo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] bcd2(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    initial begin
        cr = 1'b1; en = 1'b0; up = 1'b1; ld = 1'b0; d = 8'h00;
        w_en = 1'b0; w_up = 1'b1; w_ld = 1'b0; w_d = 16'h0000;

        // Reset held for two edges
        step();
        step();
        check("rst_q", {8'h00, q_s}, 16'h0000);
        check("rst_co", {15'd0, co_s}, 16'd0);
        check("rst_bo", {15'd0, bo_s}, 16'd0);
        check("rst_wq", w_q, 16'h0000);
        en = 1'b1; up = 1'b0; #1;
        check("rst_bo_en", {15'd0, bo_s}, 16'd1);

        // Full up-count 00..59 and wrap
        cr = 1'b0; up = 1'b1; #1;
        for (int i = 0; i < 60; i++) begin
            check("up_q", {8'h00, q_s}, {8'h00, bcd2(i)});
            check("up_co", {15'd0, co_s}, {15'd0, (i == 59)});
            check("up_bo", {15'd0, bo_s}, 16'd0);
            step();
        end
        check("up_wrap", {8'h00, q_s}, 16'h0000);

        // Down from 00 wraps to TOP
        up = 1'b0; #1;
        check("dn_bo0", {15'd0, bo_s}, 16'd1);
        check("dn_co0", {15'd0, co_s}, 16'd0);
        step(); check("dn_59", {8'h00, q_s}, 16'h0059);
        check("dn_bo59", {15'd0, bo_s}, 16'd0);
        step(); check("dn_58", {8'h00, q_s}, 16'h0058);
        step(); check("dn_57", {8'h00, q_s}, 16'h0057);

        // Load sanitising
        en = 1'b0; ld = 1'b1; d = 8'h3C;
        step(); check("ld_3C", {8'h00, q_s}, 16'h0039);
        d = 8'h75;
        step(); check("ld_75", {8'h00, q_s}, 16'h0059);
        d = 8'h42;
        step(); check("ld_42", {8'h00, q_s}, 16'h0042);
        en = 1'b1; up = 1'b1; d = 8'h10;
        step(); check("ld_en", {8'h00, q_s}, 16'h0010);
        d = 8'hFF;
        step(); check("ld_FF", {8'h00, q_s}, 16'h0059);
        ld = 1'b0;

        // 4-digit ripple
        w_ld = 1'b1; w_d = 16'h0999; w_en = 1'b1; w_up = 1'b1;
        step(); check("w_ld0999", w_q, 16'h0999);
        w_ld = 1'b0;
        step(); check("w_inc", w_q, 16'h1000);
        w_ld = 1'b1; w_d = 16'h1000;
        step(); check("w_ld1000", w_q, 16'h1000);
        w_ld = 1'b0; w_up = 1'b0;
        step(); check("w_dec", w_q, 16'h0999);
        w_ld = 1'b1; w_d = 16'h12AB;
        step(); check("w_ld12AB", w_q, 16'h1299);
        w_ld = 1'b0; w_up = 1'b1; w_d = 16'h9999; w_ld = 1'b1;
        step(); w_ld = 1'b0; #1;
        check("w_co", {15'd0, w_co}, 16'd1);
        step(); check("w_wrap", w_q, 16'h0000);
        w_en = 1'b0;

        // Priority: clear beats load and enable
        cr = 1'b1; ld = 1'b1; en = 1'b1; d = 8'h25;
        step(); check("pri_cr", {8'h00, q_s}, 16'h0000);
        cr = 1'b0; ld = 1'b1; en = 1'b0; d = 8'h59;
        step(); ld = 1'b0; up = 1'b1; #1;
        check("hold_co", {15'd0, co_s}, 16'd0);
        step(); check("hold_q", {8'h00, q_s}, 16'h0059);
        en = 1'b1; #1;
        check("top_co", {15'd0, co_s}, 16'd1);
        // Direction change mid-count
        up = 1'b0; #1;
        check("dir_co", {15'd0, co_s}, 16'd0);
        step(); check("dir_58", {8'h00, q_s}, 16'h0058);
        up = 1'b1;
        step(); check("dir_59", {8'h00, q_s}, 16'h0059);

        // Cascade: minutes advance on each seconds wrap
        cr = 1'b1;
        step();
        cr = 1'b0; en = 1'b1; up = 1'b1; ld = 1'b0;
        sec_m = 0; min_m = 0;
        for (int k = 0; k < 3600; k++) begin
            step();
            if (sec_m == 59) begin
                sec_m = 0;
                min_m = (min_m == 59) ? 0 : min_m + 1;
            end else begin
                sec_m++;
            end
            if (sec_m == 0 || sec_m == 1) begin
                check("cas_sec", {8'h00, q_s}, {8'h00, bcd2(sec_m)});
                check("cas_min", {8'h00, q_m}, {8'h00, bcd2(min_m)});
            end
        end
        check("cas_end", {q_m, q_s}, 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
